// File: rtl/ram_exercise.sv
// Single-port synchronous RAM with separate write/read strobes, registered read data,
// and an optional post-reset zero-fill sweep that holds off user strobes while it runs.
module ram_exercise #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 8,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Wr,
  input  logic              Rd,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] myOutput,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   cnt_nx_s;
  logic                clear_we_s;
  logic                wr_ok_s;
  logic                rd_ok_s;
  logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

  // CLEAR encodes as 1'b1, so busy is taken straight from the state flop
  assign busy    = (state_r == CLEAR);
  assign wr_ok_s = Wr & ~busy;
  assign rd_ok_s = Rd & ~busy;

  // Clear sequencer state and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state logic: sweep one word per cycle, leave after the last address
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    clear_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        state_nx_s = IDLE;
      end
      CLEAR: begin
        clear_we_s = 1'b1;
        cnt_nx_s   = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_r == {ADDR_W{1'b1}}) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLEAR;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Storage array; deliberately not reset so contents survive reset when not clearing
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem_r[cnt_r] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[Address] <= Data_in;
    end
  end

  // Registered read port, write-first when both strobes hit together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      myOutput <= {DATA_W{1'b0}};
    end else if (rd_ok_s) begin
      myOutput <= wr_ok_s ? Data_in : mem_r[Address];
    end
  end

endmodule

// File: tb/tb_ram_exercise.sv
// Directed bench for ram_exercise: a plain instance (no clear) driven from a vector
// table, and a clear-on-reset instance exercised with hand-written sweep sequences.
module tb_ram_exercise;

  logic       clk;
  logic       rst0;
  logic       rst1;
  logic       wr;
  logic       rd;
  logic [9:0] addr;
  logic [7:0] din;
  logic [7:0] out0;
  logic [7:0] out1;
  logic       busy0;
  logic       busy1;

  int checks;
  int errors;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  ram_exercise #(.ADDR_W(10), .DATA_W(8), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst(rst0), .Wr(wr), .Rd(rd), .Address(addr),
    .Data_in(din), .myOutput(out0), .busy(busy0)
  );

  ram_exercise #(.ADDR_W(10), .DATA_W(8), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst1), .Wr(wr), .Rd(rd), .Address(addr),
    .Data_in(din), .myOutput(out1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic r, input logic [9:0] a,
                              input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.din = d; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive on the falling edge, sample 1 time unit after the next rising edge
  task automatic cycle(input logic w, input logic r, input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  // count rising edges from now until busy1 drops; bounded
  task automatic count_busy(output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (!busy1) break;
    end
  endtask

  int n;

  initial begin
    checks = 0;
    errors = 0;
    wr = 1'b0; rd = 1'b0; addr = 10'd0; din = 8'h00;
    rst0 = 1'b0;
    rst1 = 1'b0;

    // reset with no clock edge yet
    #2;
    rst0 = 1'b1;
    rst1 = 1'b1;
    #1;
    check("reset_out0", out0, 8'h00);
    check("reset_busy0", busy0, 1'b0);
    check("reset_out1", out1, 8'h00);
    check("reset_busy1", busy1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    vq.push_back(mk(1'b1, 1'b0, 10'd0,    8'h07, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 10'd1,    8'h07, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 10'd2,    8'h07, 8'h00));
    vq.push_back(mk(1'b1, 1'b0, 10'd3,    8'h07, 8'h00));
    vq.push_back(mk(1'b0, 1'b1, 10'd3,    8'h00, 8'h07));
    vq.push_back(mk(1'b0, 1'b1, 10'd3,    8'h00, 8'h07));
    vq.push_back(mk(1'b0, 1'b1, 10'd2,    8'h00, 8'h07));
    vq.push_back(mk(1'b0, 1'b1, 10'd1,    8'h00, 8'h07));
    vq.push_back(mk(1'b0, 1'b1, 10'd0,    8'h00, 8'h07));
    vq.push_back(mk(1'b1, 1'b0, 10'd10,   8'hA5, 8'h07));
    vq.push_back(mk(1'b1, 1'b0, 10'd1023, 8'h3C, 8'h07));
    vq.push_back(mk(1'b0, 1'b1, 10'd1023, 8'h00, 8'h3C));
    vq.push_back(mk(1'b0, 1'b1, 10'd10,   8'h00, 8'hA5));
    vq.push_back(mk(1'b0, 1'b0, 10'd0,    8'h00, 8'hA5));
    vq.push_back(mk(1'b0, 1'b0, 10'd5,    8'h00, 8'hA5));
    vq.push_back(mk(1'b0, 1'b0, 10'd1023, 8'h00, 8'hA5));
    vq.push_back(mk(1'b1, 1'b0, 10'd5,    8'h11, 8'hA5));
    vq.push_back(mk(1'b1, 1'b1, 10'd5,    8'h22, 8'h22));
    vq.push_back(mk(1'b0, 1'b1, 10'd5,    8'h00, 8'h22));
    vq.push_back(mk(1'b0, 1'b0, 10'd2,    8'hFF, 8'h22));
    vq.push_back(mk(1'b0, 1'b1, 10'd2,    8'h00, 8'h07));
    vq.push_back(mk(1'b0, 1'b1, 10'd1,    8'h00, 8'h07));

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].wr, vq[i].rd, vq[i].addr, vq[i].din);
      check($sformatf("vec%0d", i), out0, vq[i].exp);
    end

    // asynchronous reset mid-operation: output forced to 0, contents kept
    rst0 = 1'b1;
    #1;
    check("midreset_out0", out0, 8'h00);
    @(negedge clk);
    rst0 = 1'b0;
    cycle(1'b0, 1'b1, 10'd10, 8'h00);
    check("after_reset_keep10", out0, 8'hA5);
    cycle(1'b0, 1'b1, 10'd1023, 8'h00);
    check("after_reset_keep1023", out0, 8'h3C);

    // clear-mode instance: let the power-up sweep finish
    n = 0;
    while (busy1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("initial_clear_done", busy1, 1'b0);

    cycle(1'b1, 1'b0, 10'd7, 8'h99);
    cycle(1'b0, 1'b1, 10'd7, 8'h00);
    check("preload7", out1, 8'h99);

    // pulse reset; strobes held active throughout the sweep must be dropped
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    check("clear_reset_out1", out1, 8'h00);
    @(negedge clk);
    rst1 = 1'b0;
    wr = 1'b1; rd = 1'b1; addr = 10'd7; din = 8'h55;
    #1;
    check("busy_after_deassert", busy1, 1'b1);
    count_busy(n);
    check("clear_len", n, 1024);
    check("out1_during_clear", out1, 8'h00);
    cycle(1'b0, 1'b1, 10'd7, 8'h00);
    check("cleared7", out1, 8'h00);
    cycle(1'b0, 1'b1, 10'd1023, 8'h00);
    check("cleared1023", out1, 8'h00);

    // restart the sweep partway through
    cycle(1'b1, 1'b0, 10'd7, 8'h99);
    cycle(1'b0, 1'b1, 10'd7, 8'h00);
    check("preload7_again", out1, 8'h99);
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("busy_mid_sweep", busy1, 1'b1);
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    count_busy(n);
    check("restart_clear_len", n, 1024);
    cycle(1'b0, 1'b1, 10'd7, 8'h00);
    check("restart_cleared7", out1, 8'h00);
    cycle(1'b1, 1'b1, 10'd600, 8'h6B);
    check("post_clear_rdw", out1, 8'h6B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_exercise.md
# ram_exercise

Single-port synchronous RAM, 1024 words x 8 bits, with separate write and read strobes and a registered read output. It is a general-purpose scratch memory for small datapaths and exercise designs. An optional post-reset clear sequencer zero-fills the array.

## Interface
- ADDR_W, 10, address width; depth = 2**ADDR_W words
- DATA_W, 8, word width
- CLEAR_ON_RESET, 0, 1 = zero-fill the whole array after every reset; 0 = contents undefined after power-up and kept across reset
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- Wr  input  1  write strobe
- Rd  input  1  read strobe
- Address  input  ADDR_W  word address, shared by read and write
- Data_in  input  DATA_W  write data
- myOutput  output  DATA_W  registered read data
- busy  output  1  high while the clear sequencer runs; strobes are ignored while high

## Operation
- Storage: array of 2**ADDR_W words of DATA_W bits. No reset on the array itself.
- Write: on a rising edge with Wr=1 and busy=0, mem[Address] <= Data_in.
- Read: on a rising edge with Rd=1 and busy=0, myOutput <= mem[Address].
- Rd=0: myOutput holds its last value.
- Wr=1 and Rd=1 on the same edge at the same address is write-first. myOutput gets Data_in, and the array is written.
- Address is always in range; all 2**ADDR_W values are valid, with no wrap or clamp logic.
- The array has no X-propagation guard. A read of a never-written word with CLEAR_ON_RESET=0 returns an undefined value.
- Clear sequencer (CLEAR_ON_RESET=1), states IDLE and CLEAR:
  - rst asserted: state <= CLEAR, clear counter <= 0.
  - CLEAR: each edge writes mem[counter] <= 0 and increments the counter.
  - After writing address 2**ADDR_W-1, go to IDLE.
  - busy = (state==CLEAR).
- With CLEAR_ON_RESET=0, the state is tied to IDLE and busy is constant 0.

## Timing
- Reset values:
  - myOutput = 0.
  - busy = 1 when CLEAR_ON_RESET=1, else 0.
  - Clear counter = 0.
- Reset acts immediately on assertion, independent of clk.
- Write latency: data is visible to a read issued on the next edge after the write edge.
- Read latency: 1 cycle. myOutput updates on the same edge that samples Rd=1 and Address.
- Back-to-back reads: a new word every cycle; Address may change every cycle.
- Clear duration: exactly 2**ADDR_W cycles after rst deasserts (1024 at default). The first accepted strobe is on the edge after busy falls.
- Reset asserted mid-clear: the sweep restarts from address 0.
- Reset asserted mid-operation: myOutput is forced to 0. Array contents are untouched when CLEAR_ON_RESET=0.
- Strobes presented while busy=1 are dropped, not queued. myOutput stays 0 during the clear.

## Test plan
- Reset: assert rst with no clock edge -> myOutput=0 immediately. With CLEAR_ON_RESET=0, busy=0.
- Write then read sequence:
  - Wr=1, Rd=0: write 8'h07 to addresses 0,1,2,3 on consecutive edges.
  - Then Wr=0, Rd=1: read addresses 3,3,2,1,0 on consecutive edges.
  - Required: myOutput=8'h07 after each read edge, with no cycle where myOutput differs.
- Distinct data and hold:
  - Write 8'hA5 to addr 10 and 8'h3C to addr 1023.
  - Read 1023 -> 8'h3C; read 10 -> 8'hA5.
  - Then Rd=0 for 3 cycles with Address changing -> myOutput stays 8'hA5.
- Read-during-write: with mem[5]=8'h11, present Wr=1, Rd=1, Address=5, Data_in=8'h22 -> myOutput=8'h22 on that edge; a later read of 5 returns 8'h22.
- Write strobe off: Wr=0, Rd=0, Data_in=8'hFF at addr 2 holding 8'h07 -> a later read of 2 returns 8'h07 (no write happened).
- Clear mode (CLEAR_ON_RESET=1):
  - Preload addr 7 with 8'h99, then pulse rst.
  - Required: busy high for exactly 1024 cycles.
  - A Wr/Rd issued during busy is ignored.
  - After busy falls, reading 7 and 1023 returns 8'h00.
  - Asserting rst at cycle 500 of the sweep restarts it, and busy lasts a full 1024 cycles from the new deassertion.
